// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake direction path.
// The same 2-bit encoding is used by the turn input stage, the direction
// FSM and the datapath, so rotations and decodes live here once.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'd0;
  localparam dir_t DIR_UP    = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_DOWN  = 2'd3;

  // Clockwise: RIGHT->DOWN->LEFT->UP->RIGHT, i.e. +3 mod 4.
  function automatic dir_t rot_cw(input dir_t d);
    return dir_t'(d + 2'd3);
  endfunction

  // Counter-clockwise: RIGHT->UP->LEFT->DOWN->RIGHT, i.e. +1 mod 4.
  function automatic dir_t rot_ccw(input dir_t d);
    return dir_t'(d + 2'd1);
  endfunction

  // One-hot decode, bit order {down, left, up, right}.
  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] oh;
    case (d)
      DIR_RIGHT: oh = 4'b0001;
      DIR_UP:    oh = 4'b0010;
      DIR_LEFT:  oh = 4'b0100;
      DIR_DOWN:  oh = 4'b1000;
      default:   oh = 4'b0001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/turn_input_ctrl_key_debounce.sv
// Key conditioner: two-flop synchroniser, level debounce counter and a
// single-cycle press pulse on each accepted released->pressed transition.
// Releases are debounced too but never produce a pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounce: count consecutive mismatches, flip the stable level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        cnt_d    = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // State flops: synchroniser, stable level, its delayed copy and the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      sync1_q      <= key_n_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // High for the one cycle after the stable level fell from released to pressed.
  assign press_o = stable_dly_q & ~stable_q;

endmodule

// File: rtl/turn_input_ctrl.sv
// Turn input stage: debounces the two turn keys, holds at most one pending
// turn and applies it on the snake step tick so the direction only ever
// changes by 90 degrees per step.
module turn_input_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       step,
  output logic       move_right,
  output logic       move_up,
  output logic       move_left,
  output logic       move_down,
  output logic       turn_pending,
  output logic [7:0] turn_count
);

  logic       press_left_s, press_right_s;
  logic       one_press_s, apply_s;
  dir_t       base_dir_s;

  dir_t       dir_q, dir_d;
  logic [3:0] dir_oh_q, dir_oh_d;
  logic       pend_q, pend_d;
  dir_t       tgt_q, tgt_d;
  logic [7:0] cnt_q, cnt_d;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_left (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (key_left_n),
    .press_o (press_left_s)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_right (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (key_right_n),
    .press_o (press_right_s)
  );

  // Simultaneous left and right presses cancel each other.
  assign one_press_s = press_left_s ^ press_right_s;
  assign apply_s     = step & pend_q;

  // Next state: apply the pending turn on step, then latch a new press
  // relative to whatever direction will be in effect after this edge.
  always_comb begin
    dir_d      = dir_q;
    dir_oh_d   = dir_oh_q;
    pend_d     = pend_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    base_dir_s = dir_q;
    if (apply_s) begin
      dir_d      = tgt_q;
      dir_oh_d   = dir_onehot(tgt_q);
      pend_d     = 1'b0;
      cnt_d      = cnt_q + 8'd1;
      base_dir_s = tgt_q;
    end else begin
      base_dir_s = dir_q;
    end
    if (one_press_s && (!pend_q || apply_s)) begin
      pend_d = 1'b1;
      if (press_left_s) begin
        tgt_d = rot_ccw(base_dir_s);
      end else begin
        tgt_d = rot_cw(base_dir_s);
      end
    end else begin
      tgt_d = tgt_q;
    end
  end

  // Direction, one-hot output copy, pending slot and turn counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q    <= DIR_RIGHT;
      dir_oh_q <= 4'b0001;
      pend_q   <= 1'b0;
      tgt_q    <= DIR_RIGHT;
      cnt_q    <= 8'd0;
    end else begin
      dir_q    <= dir_d;
      dir_oh_q <= dir_oh_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign move_right   = dir_oh_q[0];
  assign move_up      = dir_oh_q[1];
  assign move_left    = dir_oh_q[2];
  assign move_down    = dir_oh_q[3];
  assign turn_pending = pend_q;
  assign turn_count   = cnt_q;

endmodule

// File: tb/tb_turn_input_ctrl.sv
// Scoreboard bench for turn_input_ctrl with a short debounce window.
module tb_turn_input_ctrl;

  localparam logic [3:0] OH_R = 4'b0001;
  localparam logic [3:0] OH_U = 4'b0010;
  localparam logic [3:0] OH_D = 4'b1000;

  logic       clk = 1'b0;
  logic       reset, key_left_n, key_right_n, step;
  logic       move_right, move_up, move_left, move_down, turn_pending;
  logic [7:0] turn_count;

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] dir;
    logic       pend;
    logic [7:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic [12:0] last_snap;

  turn_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_left_n   (key_left_n),
    .key_right_n  (key_right_n),
    .step         (step),
    .move_right   (move_right),
    .move_up      (move_up),
    .move_left    (move_left),
    .move_down    (move_down),
    .turn_pending (turn_pending),
    .turn_count   (turn_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] snap();
    return {move_down, move_left, move_up, move_right, turn_pending, turn_count};
  endfunction

  // Monitor: every output change must match the next expected entry, including its cycle.
  always @(negedge clk) begin
    logic [12:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = snap();
      if (cur !== last_snap) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got dir=%b pend=%b cnt=%0d required no change",
                   cyc, cur[12:9], cur[8], cur[7:0]);
        end else begin
          e = exp_q.pop_front();
          if (cur !== {e.dir, e.pend, e.cnt} || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s got cyc=%0d dir=%b pend=%b cnt=%0d required cyc=%0d dir=%b pend=%b cnt=%0d",
                     e.name, cyc, cur[12:9], cur[8], cur[7:0], e.cyc, e.dir, e.pend, e.cnt);
          end
        end
        last_snap = cur;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string nm, input int c, input logic [3:0] d,
                      input logic p, input logic [7:0] n);
    exp_t e;
    e.name = nm; e.cyc = c; e.dir = d; e.pend = p; e.cnt = n;
    exp_q.push_back(e);
  endtask

  task automatic direct_check(input string nm, input logic [12:0] want);
    logic [12:0] got;
    got = snap();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, want);
    end
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; key_left_n = 1'b1; key_right_n = 1'b1; step = 1'b0;
    tick(3);
    direct_check("reset_state", {OH_R, 1'b0, 8'd0});
    reset = 1'b0;
    @(posedge clk);
    #1;
    last_snap = snap();
    mon_en = 1'b1;
    tick(50);
    direct_check("idle_50", {OH_R, 1'b0, 8'd0});

    // Bounce shorter than the window
    key_left_n = 1'b0; tick(3); key_left_n = 1'b1; tick(20);
    direct_check("bounce_ignored", {OH_R, 1'b0, 8'd0});

    // Clean left press, then step -> UP
    n = cyc;
    push("left_latch", n + 7, OH_R, 1'b1, 8'd0);
    key_left_n = 1'b0; tick(20); key_left_n = 1'b1; tick(12);
    push("step_up", cyc + 1, OH_U, 1'b0, 8'd1);
    pulse_step(); tick(10);

    // Both keys together are dropped; an idle step changes nothing
    key_left_n = 1'b0; key_right_n = 1'b0; tick(10);
    key_left_n = 1'b1; key_right_n = 1'b1; tick(12);
    pulse_step(); tick(5);
    direct_check("simultaneous_dropped", {OH_U, 1'b0, 8'd1});

    // Left press from UP latches LEFT, then reset discards it
    n = cyc;
    push("left_from_up", n + 7, OH_U, 1'b1, 8'd1);
    key_left_n = 1'b0; tick(10); key_left_n = 1'b1; tick(12);
    push("reset_pending", cyc + 1, OH_R, 1'b0, 8'd0);
    pulse_reset(); tick(5);

    // Two right presses before a step: one turn only, to DOWN
    n = cyc;
    push("right_latch", n + 7, OH_R, 1'b1, 8'd0);
    key_right_n = 1'b0; tick(10); key_right_n = 1'b1; tick(12);
    key_right_n = 1'b0; tick(10); key_right_n = 1'b1; tick(12);
    push("step_down", cyc + 1, OH_D, 1'b0, 8'd1);
    pulse_step(); tick(10);
    pulse_step(); tick(10);
    direct_check("step_no_pending", {OH_D, 1'b0, 8'd1});

    // Pending UP, right press coincides with step -> UP applied, RIGHT pending
    push("reset2", cyc + 1, OH_R, 1'b0, 8'd0);
    pulse_reset(); tick(5);
    n = cyc;
    push("left_latch2", n + 7, OH_R, 1'b1, 8'd0);
    key_left_n = 1'b0; tick(10); key_left_n = 1'b1; tick(12);
    n = cyc;
    push("step_with_press", n + 7, OH_U, 1'b1, 8'd1);
    key_right_n = 1'b0; tick(6);
    pulse_step(); tick(3);
    key_right_n = 1'b1; tick(12);
    push("step_right", cyc + 1, OH_R, 1'b0, 8'd2);
    pulse_step(); tick(5);

    // Key held through reset release -> exactly one press
    n = cyc;
    push("reset3", n + 1, OH_R, 1'b0, 8'd0);
    push("held_through_reset", n + 8, OH_R, 1'b1, 8'd0);
    key_left_n = 1'b0;
    pulse_reset();
    tick(20); key_left_n = 1'b1; tick(12);
    push("step_up2", cyc + 1, OH_U, 1'b0, 8'd1);
    pulse_step(); tick(10);
    direct_check("final_state", {OH_U, 1'b0, 8'd1});

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
